// File: rtl/fft_frame_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fft_frame_feeder
//
// Front end for the 64-point FFT core. It packs a valid/ready complex sample
// stream into N-sample frames held in a ping-pong buffer. For each full frame,
// once the core reports ready, it issues a one-cycle start pulse and then
// streams the N samples on N consecutive cycles.
//
// Optional feature: define FFT_FEEDER_SCALE_EN to pre-scale every sample on the
// read path by a rounded arithmetic right shift of SCALE_SHIFT bits. Stored
// samples always stay unscaled. In the default build, samples pass through
// bit-exact.
//
// Ports:
//   i_clk           system clock, all logic on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_s_valid       upstream sample valid
//   o_s_ready       feeder can accept a sample this cycle
//   i_s_real        signed upstream sample, real part (Q8.8)
//   i_s_imag        signed upstream sample, imaginary part (Q8.8)
//   i_fft_ready     FFT core idle and able to take a start
//   o_fft_start     one-cycle start pulse to the FFT core
//   o_fft_in_real   signed sample to the FFT core, real part
//   o_fft_in_imag   signed sample to the FFT core, imaginary part
//   o_frames_sent   count of completed frames sent, wraps 0xFFFF -> 0
//   o_busy          read FSM not in IDLE
// -----------------------------------------------------------------------------
module fft_frame_feeder #(
    parameter int N           = 64,
    parameter int ADDR_W      = 6,
    parameter int SCALE_SHIFT = 2,
    parameter int DATA_W      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_s_valid,
    output logic                     o_s_ready,
    input  logic signed [DATA_W-1:0] i_s_real,
    input  logic signed [DATA_W-1:0] i_s_imag,
    input  logic                     i_fft_ready,
    output logic                     o_fft_start,
    output logic signed [DATA_W-1:0] o_fft_in_real,
    output logic signed [DATA_W-1:0] o_fft_in_imag,
    output logic [15:0]              o_frames_sent,
    output logic                     o_busy
);

`ifdef FFT_FEEDER_SCALE_EN
    localparam bit C_SCALE_ON = 1'b1;
`else
    localparam bit C_SCALE_ON = 1'b0;
`endif

    // Rounding offset for round-half-up before the arithmetic shift.
    localparam logic signed [DATA_W:0] C_ROUND = (DATA_W+1)'(2 ** (SCALE_SHIFT - 1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } state_t;

    // One extra bit of headroom makes the rounding add overflow-free; after the
    // shift the result always fits back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] f_scale(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] ext;
        ext = {x[DATA_W-1], x};
        ext = ext + C_ROUND;
        ext = ext >>> SCALE_SHIFT;
        f_scale = C_SCALE_ON ? ext[DATA_W-1:0] : x;
    endfunction

    // Bank b occupies entries {b, addr}.
    logic signed [DATA_W-1:0] r_mem_real [2*N];
    logic signed [DATA_W-1:0] r_mem_imag [2*N];

    logic [1:0]               r_full;
    logic                     r_wr_bank;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic                     r_rd_bank;
    logic [ADDR_W-1:0]        r_rd_cnt;
    state_t                   r_state;
    logic [15:0]              r_frames_sent;
    logic                     r_fft_start;
    logic                     r_busy;
    logic signed [DATA_W-1:0] r_real_p1;
    logic signed [DATA_W-1:0] r_imag_p1;

    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        w_rd_cnt_nxt;
    logic                     w_rd_done;
    logic                     w_wr_fire;
    logic                     w_wr_last;
    logic [1:0]               w_full_set;
    logic [1:0]               w_full_clr;
    logic signed [DATA_W-1:0] w_rd_real_p0;
    logic signed [DATA_W-1:0] w_rd_imag_p0;

    // ---------------------------------------------------------------- write side
    assign o_s_ready  = !r_full[r_wr_bank];
    assign w_wr_fire  = i_s_valid && o_s_ready;
    assign w_wr_last  = w_wr_fire && (r_wr_addr == ADDR_W'(N - 1));
    assign w_full_set = {w_wr_last & r_wr_bank, w_wr_last & ~r_wr_bank};
    assign w_full_clr = {w_rd_done & r_rd_bank, w_rd_done & ~r_rd_bank};

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem_real[{r_wr_bank, r_wr_addr}] <= i_s_real;
            r_mem_imag[{r_wr_bank, r_wr_addr}] <= i_s_imag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_addr <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wr_addr <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
        end
    end

    // A set and a clear can land together only on different banks: the bank
    // being read is full, so it cannot be the one being written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // ---------------------------------------------------------------- read FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_cnt_nxt = r_rd_cnt;
        w_rd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_full[r_rd_bank] && i_fft_ready) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt  = STREAM;
                w_rd_cnt_nxt = '0;
            end
            STREAM: begin
                if (r_rd_cnt == ADDR_W'(N - 1)) begin
                    w_rd_done    = 1'b1;
                    w_state_nxt  = IDLE;
                    w_rd_cnt_nxt = '0;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_rd_cnt      <= '0;
            r_rd_bank     <= 1'b0;
            r_frames_sent <= 16'd0;
            r_fft_start   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_fft_start <= (w_state_nxt == START);
            r_busy      <= (w_state_nxt != IDLE);
            if (w_rd_done) begin
                r_rd_bank     <= ~r_rd_bank;
                r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

    // ---------------------------------------------------------------- stage p0: buffer read
    // Addressed with the next read count so sample k is registered out in the
    // (k+1)-th cycle after the start cycle.
    assign w_rd_real_p0 = r_mem_real[{r_rd_bank, w_rd_cnt_nxt}];
    assign w_rd_imag_p0 = r_mem_imag[{r_rd_bank, w_rd_cnt_nxt}];

    // ---------------------------------------------------------------- stage p1: output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_real_p1 <= '0;
            r_imag_p1 <= '0;
        end else if (w_state_nxt == STREAM) begin
            r_real_p1 <= f_scale(w_rd_real_p0);
            r_imag_p1 <= f_scale(w_rd_imag_p0);
        end else begin
            r_real_p1 <= '0;
            r_imag_p1 <= '0;
        end
    end

    assign o_fft_start   = r_fft_start;
    assign o_fft_in_real = r_real_p1;
    assign o_fft_in_imag = r_imag_p1;
    assign o_frames_sent = r_frames_sent;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_fft_frame_feeder.sv
`timescale 1ns/1ps
module tb_fft_frame_feeder;
    localparam int N = 64;

    logic               clk;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_real;
    logic signed [15:0] s_imag;
    logic               fft_ready;
    logic               fft_start;
    logic signed [15:0] fft_in_real;
    logic signed [15:0] fft_in_imag;
    logic [15:0]        frames_sent;
    logic               busy;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: every accepted sample in order; frame f is entries f*N..f*N+N-1.
    logic signed [15:0] q_real[$];
    logic signed [15:0] q_imag[$];
    int n_acc = 0;
    int n_done = 0;

    fft_frame_feeder dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_s_valid     (s_valid),
        .o_s_ready     (s_ready),
        .i_s_real      (s_real),
        .i_s_imag      (s_imag),
        .i_fft_ready   (fft_ready),
        .o_fft_start   (fft_start),
        .o_fft_in_real (fft_in_real),
        .o_fft_in_imag (fft_in_imag),
        .o_frames_sent (frames_sent),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Expected value of a stored sample as it leaves on fft_in_*.
    function automatic logic signed [15:0] ref_out(input logic signed [15:0] x);
`ifdef FFT_FEEDER_SCALE_EN
        int v;
        v = int'(x) + 2;
        if (v >= 0) return 16'(v / 4);
        else        return 16'(-((-v + 3) / 4));
`else
        return x;
`endif
    endfunction

    function automatic int stored();
        return n_acc - N * n_done;
    endfunction

    task automatic model_clear();
        q_real.delete();
        q_imag.delete();
        n_acc  = 0;
        n_done = 0;
    endtask

    // Advance one cycle; record the handshake of the cycle being left.
    task automatic tick();
        bit hs;
        hs = s_valid && s_ready && rst_n;
        @(posedge clk);
        if (hs) begin
            q_real.push_back(s_real);
            q_imag.push_back(s_imag);
            n_acc++;
        end
        #1;
    endtask

    task automatic test_reset();
        s_valid = 0; fft_ready = 0; s_real = 0; s_imag = 0;
        model_clear();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({fft_start, busy} !== 2'b00) $display("FAIL reset_ctrl: start/busy=%b want 00", {fft_start, busy}); else n_pass++;
        n_total++; if (fft_in_real !== 16'sd0 || fft_in_imag !== 16'sd0) $display("FAIL reset_data: got %h/%h want 0/0", fft_in_real, fft_in_imag); else n_pass++;
        n_total++; if (frames_sent !== 16'd0) $display("FAIL reset_frames: got %0d want 0", frames_sent); else n_pass++;
        rst_n = 1;
        n_total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
        tick();
        n_total++; if ({s_ready, busy, fft_start} !== 3'b100) $display("FAIL reset_after: ready/busy/start=%b want 100", {s_ready, busy, fft_start}); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic signed [15:0] er, ei;
        fft_ready = 1;
        for (int k = 0; k < N; k++) begin
            s_valid = 1; s_real = 16'(k * 256); s_imag = 16'(-k);
            n_total++; if (s_ready !== 1'b1) $display("FAIL single_push_ready k=%0d: got %b want 1", k, s_ready); else n_pass++;
            tick();
        end
        s_valid = 0; s_real = 0; s_imag = 0;
        // Now in cycle c+1, where c carried the last handshake.
        for (int j = 1; j <= N + 3; j++) begin
            if (j >= 3 && j <= N + 2) begin
                er = ref_out(16'((j - 3) * 256));
                ei = ref_out(16'(-(j - 3)));
            end else begin
                er = 0; ei = 0;
            end
            n_total++; if (fft_start !== (j == 2)) $display("FAIL single_start c+%0d: got %b want %b", j, fft_start, (j == 2)); else n_pass++;
            n_total++; if (fft_in_real !== er || fft_in_imag !== ei) $display("FAIL single_data c+%0d: got %h/%h want %h/%h", j, fft_in_real, fft_in_imag, er, ei); else n_pass++;
            tick();
        end
        n_done++;
        n_total++; if (frames_sent !== 16'd1) $display("FAIL single_frames: got %0d want 1", frames_sent); else n_pass++;
        n_total++; if ({busy, s_ready} !== 2'b01) $display("FAIL single_idle: busy/ready=%b want 01", {busy, s_ready}); else n_pass++;
        fft_ready = 0;
    endtask

    task automatic test_backpressure();
        int  acc0;
        bit  saw_start;
        bit  got;
        int  idx;
        fft_ready = 0; saw_start = 0; acc0 = n_acc;
        for (int i = 0; i < 140; i++) begin
            s_valid = 1; s_real = 16'($urandom); s_imag = 16'($urandom);
            if (fft_start) saw_start = 1;
            tick();
        end
        s_valid = 0;
        n_total++; if (n_acc - acc0 !== 128) $display("FAIL bp_accepted: got %0d want 128", n_acc - acc0); else n_pass++;
        n_total++; if (s_ready !== 1'b0) $display("FAIL bp_stall: s_ready=%b want 0", s_ready); else n_pass++;
        n_total++; if (saw_start !== 1'b0) $display("FAIL bp_no_start: start seen=%b want 0", saw_start); else n_pass++;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                fft_ready = 0; saw_start = 0;
                for (int i = 0; i < 200; i++) begin
                    if (fft_start) saw_start = 1;
                    tick();
                end
                n_total++; if (saw_start !== 1'b0) $display("FAIL bp_hold_start: start seen=%b want 0", saw_start); else n_pass++;
            end
            fft_ready = 1; got = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                tick();
                if (fft_start) got = 1;
            end
            n_total++; if (!got) $display("FAIL bp_start_timeout frame %0d: start=%b want 1", f, fft_start); else n_pass++;
            fft_ready = 0;
            if (got) begin
                for (int k = 0; k < N; k++) begin
                    tick();
                    idx = n_done * N + k;
                    n_total++; if (fft_in_real !== ref_out(q_real[idx]) || fft_in_imag !== ref_out(q_imag[idx]))
                        $display("FAIL bp_data f%0d k=%0d: got %h/%h want %h/%h", f, k, fft_in_real, fft_in_imag, ref_out(q_real[idx]), ref_out(q_imag[idx]));
                    else n_pass++;
                    n_total++; if (s_ready !== (stored() < 2 * N)) $display("FAIL bp_ready_stream f%0d k=%0d: got %b want %b", f, k, s_ready, (stored() < 2 * N)); else n_pass++;
                end
                n_done++;
                tick();
                n_total++; if (s_ready !== 1'b1) $display("FAIL bp_ready_after f%0d: got %b want 1", f, s_ready); else n_pass++;
                n_total++; if (frames_sent !== 16'(n_done)) $display("FAIL bp_frames f%0d: got %0d want %0d", f, frames_sent, n_done); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit got;
        int idx;
        bit saw_start;
        fft_ready = 1;
        for (int k = 0; k < N; k++) begin
            s_valid = 1; s_real = 16'($urandom); s_imag = 16'($urandom);
            tick();
        end
        s_valid = 0; got = 0;
        for (int w = 0; w < 8 && !got; w++) begin
            tick();
            if (fft_start) got = 1;
        end
        n_total++; if (!got) $display("FAIL rst_mid_start_timeout: start=%b want 1", fft_start); else n_pass++;
        repeat (21) tick();
        idx = n_done * N + 20;
        n_total++; if (fft_in_real !== ref_out(q_real[idx])) $display("FAIL rst_mid_sample20: got %h want %h", fft_in_real, ref_out(q_real[idx])); else n_pass++;
        rst_n = 0;
        #1;
        n_total++; if ({fft_start, busy} !== 2'b00) $display("FAIL rst_mid_ctrl: start/busy=%b want 00", {fft_start, busy}); else n_pass++;
        n_total++; if (fft_in_real !== 16'sd0 || fft_in_imag !== 16'sd0) $display("FAIL rst_mid_data: got %h/%h want 0/0", fft_in_real, fft_in_imag); else n_pass++;
        n_total++; if (frames_sent !== 16'd0) $display("FAIL rst_mid_frames: got %0d want 0", frames_sent); else n_pass++;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n_total++; if (s_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", s_ready); else n_pass++;
        saw_start = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (fft_start || busy) saw_start = 1;
        end
        n_total++; if (saw_start !== 1'b0) $display("FAIL rst_mid_residual: start/busy seen=%b want 0", saw_start); else n_pass++;
    endtask

    task automatic test_scale();
        bit got;
        int idx;
        logic signed [15:0] er0, ei0, er1, ei1;
`ifdef FFT_FEEDER_SCALE_EN
        er0 = 16'h0041; ei0 = 16'hFFFF; er1 = 16'h2000; ei1 = 16'h2000;
`else
        er0 = 16'h0103; ei0 = 16'hFFFB; er1 = 16'h7FFF; ei1 = 16'h7FFF;
`endif
        fft_ready = 1;
        for (int k = 0; k < N; k++) begin
            s_valid = 1;
            if (k == 0)      begin s_real = 16'h0103; s_imag = -16'sd5; end
            else if (k == 1) begin s_real = 16'h7FFF; s_imag = 16'h7FFF; end
            else if (k == 2) begin s_real = 16'h8000; s_imag = 16'h8001; end
            else             begin s_real = 16'($urandom); s_imag = 16'($urandom); end
            tick();
        end
        s_valid = 0; got = 0;
        for (int w = 0; w < 8 && !got; w++) begin
            tick();
            if (fft_start) got = 1;
        end
        n_total++; if (!got) $display("FAIL scale_start_timeout: start=%b want 1", fft_start); else n_pass++;
        fft_ready = 0;
        if (got) begin
            for (int k = 0; k < N; k++) begin
                tick();
                idx = n_done * N + k;
                if (k == 0) begin
                    n_total++; if (fft_in_real !== er0 || fft_in_imag !== ei0) $display("FAIL scale_s0: got %h/%h want %h/%h", fft_in_real, fft_in_imag, er0, ei0); else n_pass++;
                end else if (k == 1) begin
                    n_total++; if (fft_in_real !== er1 || fft_in_imag !== ei1) $display("FAIL scale_s1: got %h/%h want %h/%h", fft_in_real, fft_in_imag, er1, ei1); else n_pass++;
                end else begin
                    n_total++; if (fft_in_real !== ref_out(q_real[idx]) || fft_in_imag !== ref_out(q_imag[idx]))
                        $display("FAIL scale_data k=%0d: got %h/%h want %h/%h", k, fft_in_real, fft_in_imag, ref_out(q_real[idx]), ref_out(q_imag[idx]));
                    else n_pass++;
                end
            end
            n_done++;
            tick();
        end
    endtask

    task automatic test_random_traffic();
        bit streaming;
        int k;
        int core_cnt;
        int idx;
        streaming = 0; k = 0; core_cnt = 0; fft_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            n_total++; if (s_ready !== (stored() < 2 * N)) $display("FAIL rnd_ready cyc %0d: got %b want %b", i, s_ready, (stored() < 2 * N)); else n_pass++;
            n_total++; if (frames_sent !== 16'(n_done)) $display("FAIL rnd_frames cyc %0d: got %0d want %0d", i, frames_sent, n_done); else n_pass++;
            if (streaming) begin
                idx = n_done * N + k;
                n_total++; if ({fft_start, busy} !== 2'b01) $display("FAIL rnd_stream_ctrl cyc %0d: start/busy=%b want 01", i, {fft_start, busy}); else n_pass++;
                n_total++; if (fft_in_real !== ref_out(q_real[idx]) || fft_in_imag !== ref_out(q_imag[idx]))
                    $display("FAIL rnd_data cyc %0d k=%0d: got %h/%h want %h/%h", i, k, fft_in_real, fft_in_imag, ref_out(q_real[idx]), ref_out(q_imag[idx]));
                else n_pass++;
                k++;
                if (k == N) begin streaming = 0; n_done++; end
            end else if (fft_start) begin
                n_total++; if (!(stored() >= N && fft_ready)) $display("FAIL rnd_start_cond cyc %0d: stored=%0d ready=%b want >=64 and 1", i, stored(), fft_ready); else n_pass++;
                n_total++; if (busy !== 1'b1 || fft_in_real !== 16'sd0) $display("FAIL rnd_start_out cyc %0d: busy=%b real=%h want 1/0", i, busy, fft_in_real); else n_pass++;
                streaming = 1; k = 0;
                core_cnt = N + int'($urandom_range(0, 40));
            end else begin
                n_total++; if (busy !== 1'b0 || fft_in_real !== 16'sd0 || fft_in_imag !== 16'sd0)
                    $display("FAIL rnd_idle cyc %0d: busy=%b data=%h/%h want 0/0/0", i, busy, fft_in_real, fft_in_imag);
                else n_pass++;
            end
            if (core_cnt > 0) core_cnt--;
            else if ($urandom_range(0, 7) == 0) core_cnt = int'($urandom_range(1, 20));
            fft_ready = (core_cnt == 0);
            s_valid = (i < 2500) ? ($urandom_range(0, 3) != 0) : 1'b0;
            s_real = 16'($urandom); s_imag = 16'($urandom);
            tick();
        end
        n_total++; if (stored() >= N || streaming) $display("FAIL rnd_drain: stored=%0d streaming=%b want <64 and 0", stored(), streaming); else n_pass++;
    endtask

    initial begin
        rst_n = 0; s_valid = 0; fft_ready = 0; s_real = 0; s_imag = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_reset_mid_stream();
        test_scale();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
